// File: rtl/barebones_irq_ctrl_if.sv
// Wishbone classic bus between the core (master) and the interrupt controller (slave).
interface barebones_irq_ctrl_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [1:0]  adr;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic        ack;

  modport master (output cyc, stb, we, adr, wdat, input rdat, ack);
  modport slave  (input cyc, stb, we, adr, wdat, output rdat, ack);
endinterface

// File: rtl/barebones_irq_ctrl.sv
// External interrupt controller: synchronised level/edge sources, lowest-index priority,
// single-claim handshake with the core, and PENDING/ENABLE/EDGE/CLAIM Wishbone registers.
module barebones_irq_ctrl #(
  parameter int unsigned N_SRC       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [N_SRC-1:0]     irq_src_i,
  output logic                 meip_o,
  input  logic                 irq_ack_i,
  barebones_irq_ctrl_if.slave  wb
);

  typedef enum logic {IDLE, CLAIMED} state_e;

  state_e           state_q;
  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] s, s_d_q, rise;
  logic [N_SRC-1:0] pend_q, pend_d, en_q, edge_type_q;
  logic [N_SRC-1:0] req, lowest, claim_clr, w1c;
  logic [4:0]       claim_id_q, claim_id_d;
  logic             meip_q, ack_q;
  logic [31:0]      rdat_q, rdat_d;
  logic             access, wr_en, claim_fire, complete;
  logic             unused_wdat;

  always_comb begin
    s      = sync_q[SYNC_STAGES-1];
    rise   = s & ~s_d_q;
    req    = pend_q & en_q;
    // Two's-complement trick isolates the lowest set request bit.
    lowest = req & (~req + N_SRC'(1));

    access     = wb.cyc & wb.stb & ~ack_q;
    wr_en      = access & wb.we;
    claim_fire = irq_ack_i & meip_q & (state_q == IDLE) & (|req);
    complete   = wr_en & (wb.adr == 2'd3) & (state_q == CLAIMED);

    claim_id_d = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (lowest[i]) claim_id_d = 5'(i + 1);
    end

    claim_clr = claim_fire ? (lowest & edge_type_q) : '0;
    w1c       = (wr_en && wb.adr == 2'd0) ? wb.wdat[N_SRC-1:0] : '0;
    // Edge bits: a rise in the same cycle as a clear keeps the bit set.
    pend_d    = (edge_type_q & ((pend_q & ~(claim_clr | w1c)) | rise))
              | (~edge_type_q & s);

    rdat_d = '0;
    unique case (wb.adr)
      2'd0: rdat_d = 32'(pend_q);
      2'd1: rdat_d = 32'(en_q);
      2'd2: rdat_d = 32'(edge_type_q);
      2'd3: rdat_d = 32'(claim_id_q);
      default: rdat_d = '0;
    endcase

    unused_wdat = ^wb.wdat;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      s_d_q       <= '0;
      pend_q      <= '0;
      en_q        <= '0;
      edge_type_q <= '0;
      meip_q      <= 1'b0;
      ack_q       <= 1'b0;
      rdat_q      <= '0;
      state_q     <= IDLE;
      claim_id_q  <= '0;
    end else begin
      sync_q[0] <= irq_src_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      s_d_q  <= s;
      pend_q <= pend_d;
      ack_q  <= wb.cyc & wb.stb & ~ack_q;
      if (access) rdat_q <= rdat_d;
      if (wr_en && wb.adr == 2'd1) en_q        <= wb.wdat[N_SRC-1:0];
      if (wr_en && wb.adr == 2'd2) edge_type_q <= wb.wdat[N_SRC-1:0];
      // Gated by the current state, so a complete re-raises the request one cycle later.
      meip_q <= (|req) & (state_q == IDLE) & ~claim_fire;
      unique case (state_q)
        IDLE: if (claim_fire) begin
          state_q    <= CLAIMED;
          claim_id_q <= claim_id_d;
        end
        CLAIMED: if (complete) begin
          state_q    <= IDLE;
          claim_id_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign meip_o  = meip_q;
  assign wb.ack  = ack_q;
  assign wb.rdat = rdat_q;

endmodule
